// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package inst_fetch_pkg;

  localparam logic [6:0] OPC_JAL = 7'd111;
  localparam logic [6:0] OPC_BR  = 7'd99;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_BUSY = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  // 65-bit queue entry: instruction, predicted-taken flag, non-predicted pc
  typedef struct packed {
    logic [31:0] instr;
    logic        isjump;
    logic [31:0] alt_pc;
  } iq_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] d);
    return {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] d);
    return {{20{d[31]}}, d[7], d[30:25], d[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// In-order circular instruction queue (inst_queue) with synchronous flush.
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  iq_entry_t            push_data,
  input  logic                 pop,
  output iq_entry_t            head,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG:0]   CNT_ONE = 1;

  iq_entry_t              entries_q [DEPTH];
  logic [DEPTH_LOG-1:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0]     count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: the count alone defines which slots are live
  always_ff @(posedge clk) begin
    if (push && !flush) entries_q[tail_q] <= push_data;
  end

  assign head  = entries_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: one outstanding word fetch, static/BHT next-pc prediction, instruction queue.
// Optional branch history table enabled by defining IF_BHT_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          IQ_DEPTH_LOG = 3,
  parameter int          BHT_IDX_W    = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic [31:0] jump_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        update_instr_valid,
  output logic [31:0] update_instr,
  output logic        update_instr_isjump,
  output logic [31:0] update_instr_jump_wrong_to_pc,
  input  logic        Decoder_not_ready_accept,
  input  logic        bht_upd_valid,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken
);

  localparam logic [IQ_DEPTH_LOG:0] DEPTH_CNT = (IQ_DEPTH_LOG+1)'(1 << IQ_DEPTH_LOG);

  if_state_e               state_q, state_d;
  logic [31:0]             pc_q, pc_d, req_addr_q, req_addr_d;
  logic [IQ_DEPTH_LOG:0]   count;
  iq_entry_t               head, push_entry;
  logic                    push, pop, flush, has_room, predict_taken;
  logic [6:0]              opcode;
  logic [31:0]             seq_pc, br_target, next_pc;

  inst_queue #(.DEPTH_LOG(IQ_DEPTH_LOG)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign update_instr_valid            = (count != '0);
  assign update_instr                  = update_instr_valid ? head.instr  : '0;
  assign update_instr_isjump           = update_instr_valid & head.isjump;
  assign update_instr_jump_wrong_to_pc = update_instr_valid ? head.alt_pc : '0;
  assign mem_req_valid                 = (state_q != IF_IDLE);
  assign mem_req_addr                  = req_addr_q;

  always_comb begin
    opcode            = mem_resp_data[6:0];
    seq_pc            = pc_q + 32'd4;
    br_target         = pc_q + imm_b(mem_resp_data);
    next_pc           = seq_pc;
    push_entry.instr  = mem_resp_data;
    push_entry.isjump = 1'b0;
    push_entry.alt_pc = seq_pc;
    if (opcode == OPC_JAL) begin
      push_entry.isjump = 1'b1;
      next_pc           = pc_q + imm_j(mem_resp_data);
    end else if (opcode == OPC_BR) begin
      if (predict_taken) begin
        push_entry.isjump = 1'b1;
        next_pc           = br_target;
      end else begin
        push_entry.alt_pc = br_target;
      end
    end
  end

  // Issue is gated so queued entries plus the one in-flight fetch never exceed the depth
  assign pop      = rdy && update_instr_valid && !Decoder_not_ready_accept && !jump_wrong;
  assign has_room = pop || (count != DEPTH_CNT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (rdy) begin
      if (jump_wrong) begin
        flush = 1'b1;
        pc_d  = jump_pc;
        // A fetch still in flight must be drained; one completing now is simply discarded
        state_d = (state_q == IF_IDLE || mem_resp_valid) ? IF_IDLE : IF_DROP;
      end else begin
        case (state_q)
          IF_IDLE: if (has_room) begin
            state_d    = IF_BUSY;
            req_addr_d = pc_q;
          end
          IF_BUSY: if (mem_resp_valid) begin
            push    = 1'b1;
            pc_d    = next_pc;
            state_d = IF_IDLE;
          end
          IF_DROP: if (mem_resp_valid) state_d = IF_IDLE;
          default: state_d = IF_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IF_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

`ifdef IF_BHT_EN
  localparam int BHT_SIZE = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [BHT_SIZE];
  logic [1:0]           bht_d [BHT_SIZE];
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_upd_bits;

  assign upd_idx         = bht_upd_pc[BHT_IDX_W+1:2];
  assign predict_taken   = bht_q[pc_q[BHT_IDX_W+1:2]][1];
  assign unused_upd_bits = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

  always_comb begin
    bht_d = bht_q;
    if (rdy && bht_upd_valid) begin
      if (bht_upd_taken && bht_q[upd_idx] != 2'b11)
        bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      else if (!bht_upd_taken && bht_q[upd_idx] != 2'b00)
        bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_SIZE; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_bht;

  assign predict_taken = 1'b0;
  assign unused_bht    = ^{bht_upd_valid, bht_upd_taken, bht_upd_pc};
`endif

endmodule
